// File: rtl/mac_accumulator.sv
// Two-stage signed multiply-accumulate: registers one product per active_MAC pulse,
// sums TERMS of them and emits one saturated result with a single-cycle valid pulse.
module mac_accumulator #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TERMS  = 8,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     reset_MAC,
    input  logic                     active_MAC,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [COEF_W-1:0]        coef_in,
    output logic [OUT_W-1:0]         result,
    output logic                     result_valid,
    output logic                     overflow,
    output logic                     busy,
    output logic [$clog2(TERMS)-1:0] term_count
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CNT_W  = $clog2(TERMS);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(TERMS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_clipped(input logic signed [ACC_W-1:0] v);
        is_clipped = (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic [OUT_W-1:0] sat_value(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            sat_value = OUT_MAX;
        end else if (v < SAT_MIN) begin
            sat_value = OUT_MIN;
        end else begin
            sat_value = v[OUT_W-1:0];
        end
    endfunction

    logic signed [PROD_W-1:0] data_ext_s;
    logic signed [PROD_W-1:0] coef_ext_s;
    logic signed [PROD_W-1:0] mult_s;
    logic signed [PROD_W-1:0] product_r;
    logic                     p_valid_r;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W-1:0]  acc_r;
    state_t                   state_r;

    // Operands are sign-extended to the full product width before multiplying.
    assign data_ext_s = {{COEF_W{data_in[DATA_W-1]}}, data_in};
    assign coef_ext_s = {{DATA_W{coef_in[COEF_W-1]}}, coef_in};
    assign mult_s     = data_ext_s * coef_ext_s;
    assign prod_ext_s = {{(ACC_W-PROD_W){product_r[PROD_W-1]}}, product_r};
    assign sum_s      = acc_r + prod_ext_s;

    assign busy = (state_r == ACCUM) || p_valid_r;

    // Stage 1: product register and its valid flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            product_r <= {PROD_W{1'b0}};
            p_valid_r <= 1'b0;
        end else if (reset_MAC) begin
            p_valid_r <= 1'b0;
        end else if (active_MAC) begin
            product_r <= mult_s;
            p_valid_r <= 1'b1;
        end else begin
            p_valid_r <= 1'b0;
        end
    end

    // Stage 2: accumulate TERMS products, then finalise a saturated result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_r        <= {ACC_W{1'b0}};
            term_count   <= {CNT_W{1'b0}};
            result       <= {OUT_W{1'b0}};
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            state_r      <= IDLE;
        end else if (reset_MAC) begin
            acc_r        <= {ACC_W{1'b0}};
            term_count   <= {CNT_W{1'b0}};
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            state_r      <= IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    result_valid <= 1'b0;
                    if (p_valid_r) begin
                        acc_r      <= prod_ext_s;
                        term_count <= CNT_W'(1);
                        state_r    <= ACCUM;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ACCUM: begin
                    result_valid <= 1'b0;
                    if (p_valid_r) begin
                        if (term_count == LAST_CNT) begin
                            // Final term: the sum is clamped straight into result.
                            result       <= sat_value(sum_s);
                            result_valid <= 1'b1;
                            overflow     <= overflow | is_clipped(sum_s);
                            acc_r        <= {ACC_W{1'b0}};
                            term_count   <= {CNT_W{1'b0}};
                            state_r      <= DONE;
                        end else begin
                            acc_r      <= sum_s;
                            term_count <= term_count + CNT_W'(1);
                            state_r    <= ACCUM;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                default: begin
                    acc_r        <= {ACC_W{1'b0}};
                    term_count   <= {CNT_W{1'b0}};
                    result_valid <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomised and directed bench for mac_accumulator against a per-block sum model.
module tb_mac_accumulator;

    localparam int TERMS = 8;
    localparam int OUT_MAXI = 32767;
    localparam int OUT_MINI = -32768;

    logic        clock;
    logic        reset;
    logic        reset_MAC;
    logic        active_MAC;
    logic [7:0]  data_in;
    logic [7:0]  coef_in;
    logic [15:0] result;
    logic        result_valid;
    logic        overflow;
    logic        busy;
    logic [2:0]  term_count;

    mac_accumulator #(
        .DATA_W(8), .COEF_W(8), .TERMS(TERMS), .ACC_W(20), .OUT_W(16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .reset_MAC   (reset_MAC),
        .active_MAC  (active_MAC),
        .data_in     (data_in),
        .coef_in     (coef_in),
        .result      (result),
        .result_valid(result_valid),
        .overflow    (overflow),
        .busy        (busy),
        .term_count  (term_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: pending term from last edge, running block sum and term count.
    int m_sum, m_cnt, m_res, m_pend_prod;
    bit m_pend, m_valid, m_ovf;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_sum = 0; m_cnt = 0; m_res = 0; m_pend_prod = 0;
            m_pend = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
        end else if (reset_MAC) begin
            m_sum = 0; m_cnt = 0; m_pend = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_pend) begin
                m_sum += m_pend_prod;
                m_cnt++;
                if (m_cnt == TERMS) begin
                    if (m_sum > OUT_MAXI) begin
                        m_res = OUT_MAXI; m_ovf = 1'b1;
                    end else if (m_sum < OUT_MINI) begin
                        m_res = OUT_MINI; m_ovf = 1'b1;
                    end else begin
                        m_res = m_sum;
                    end
                    m_valid = 1'b1;
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
            m_pend = active_MAC;
            if (active_MAC) m_pend_prod = int'($signed(data_in)) * int'($signed(coef_in));
        end
    end

    int cycle = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;
    int pulse_cyc_prev = 0;
    logic [15:0] last_res = 16'd0;
    logic [15:0] exp_res16;

    // Per-cycle comparison of every output against the reference.
    always @(negedge clock) begin
        cycle++;
        exp_res16 = m_res[15:0];
        chk("result", {16'd0, result}, {16'd0, exp_res16});
        chk("result_valid", {31'd0, result_valid}, {31'd0, m_valid});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("busy", {31'd0, busy}, {31'd0, (m_cnt != 0) || m_pend});
        chk("term_count", {29'd0, term_count}, m_cnt);
        if (result_valid) begin
            pulse_cnt++;
            last_res = result;
            pulse_cyc_prev = pulse_cyc;
            pulse_cyc = cycle;
        end
    end

    task automatic drive(input logic a, input logic [7:0] d, input logic [7:0] c, input logic rm);
        @(posedge clock);
        #1;
        active_MAC = a; data_in = d; coef_in = c; reset_MAC = rm;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic terms(input int n, input logic [7:0] d, input logic [7:0] c);
        for (int i = 0; i < n; i++) drive(1'b1, d, c, 1'b0);
    endtask

    task automatic settle;
        idle(3);
        @(negedge clock);
        #1;
    endtask

    task automatic async_reset_check;
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_term_count", {29'd0, term_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        active_MAC = 1'b0; reset_MAC = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    int p0;
    logic [7:0] neg5;
    logic [7:0] neg128;

    initial begin
        reset = 1'b0; reset_MAC = 1'b0; active_MAC = 1'b0;
        data_in = 8'd0; coef_in = 8'd0;
        neg5 = 8'hFB; neg128 = 8'h80;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        idle(2);

        // Basic block: 1..8 times 2 = 72
        p0 = pulse_cnt;
        for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 8'd2, 1'b0);
        settle();
        chk("basic_pulses", pulse_cnt - p0, 32'd1);
        chk("basic_result", {16'd0, last_res}, 32'd72);
        chk("basic_model", m_res, 32'd72);
        chk("basic_overflow", {31'd0, overflow}, 32'd0);

        async_reset_check();
        idle(2);

        // Gapped cadence: 8 x (3 * -5) = -120
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'd3, neg5, 1'b0);
            idle(3);
        end
        settle();
        chk("gapped_result", {16'd0, last_res}, 32'h0000FF88);

        // Saturation then a clean block with sticky overflow
        terms(8, neg128, 8'd127);
        settle();
        chk("sat_result", {16'd0, last_res}, 32'h00008000);
        chk("sat_overflow", {31'd0, overflow}, 32'd1);
        chk("sat_model", {31'd0, m_ovf}, 32'd1);
        terms(8, 8'd1, 8'd1);
        settle();
        chk("post_sat_result", {16'd0, last_res}, 32'd8);
        chk("post_sat_overflow", {31'd0, overflow}, 32'd1);

        // Mid-block clear: 5 terms discarded, next block gives 8
        p0 = pulse_cnt;
        terms(5, 8'd1, 8'd1);
        drive(1'b0, 8'd0, 8'd0, 1'b1);
        terms(8, 8'd1, 8'd1);
        settle();
        chk("clear_pulses", pulse_cnt - p0, 32'd1);
        chk("clear_result", {16'd0, last_res}, 32'd8);
        chk("clear_overflow", {31'd0, overflow}, 32'd0);

        // reset_MAC with the 8th term's active_MAC, then with its landing edge
        p0 = pulse_cnt;
        terms(7, 8'd1, 8'd1);
        drive(1'b1, 8'd1, 8'd1, 1'b1);
        idle(2);
        terms(8, 8'd1, 8'd1);
        drive(1'b0, 8'd0, 8'd0, 1'b1);
        settle();
        chk("suppress_pulses", pulse_cnt - p0, 32'd0);

        // Back-to-back blocks: two pulses of 32, eight cycles apart
        p0 = pulse_cnt;
        terms(16, 8'd2, 8'd2);
        settle();
        chk("b2b_pulses", pulse_cnt - p0, 32'd2);
        chk("b2b_result", {16'd0, last_res}, 32'd32);
        chk("b2b_spacing", pulse_cyc - pulse_cyc_prev, 32'd8);

        // Async reset during a third block, then a fresh block
        terms(4, 8'd2, 8'd2);
        async_reset_check();
        p0 = pulse_cnt;
        terms(8, 8'd2, 8'd2);
        settle();
        chk("after_reset_pulses", pulse_cnt - p0, 32'd1);
        chk("after_reset_result", {16'd0, last_res}, 32'd32);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0,
                  8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 59) == 0);
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
